// File: rtl/manchester_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : manchester_pkg
//  Brief    : Shared types and phase constants for the Manchester receiver.
//  Revision : 1.0  initial release
// ============================================================================
package manchester_pkg;

  // Receiver state: waiting for line quiet, armed for start edge, in frame
  typedef enum logic [1:0] {
    QUIET = 2'd0,
    IDLE  = 2'd1,
    DATA  = 2'd2
  } state_e;

  // Default oversampling ratio and derived sample points
  localparam int unsigned OSR_DEFAULT    = 8;
  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam int unsigned QTR            = OSR_DEFAULT / 4;
  localparam int unsigned A_PHASE        = 3 * OSR_DEFAULT / 4;
  localparam int unsigned B_PHASE        = OSR_DEFAULT / 4;

  // First-half sample point for an arbitrary oversampling ratio
  function automatic int unsigned a_phase(input int unsigned osr);
    return (3 * osr) / 4;
  endfunction

  // Second-half sample point for an arbitrary oversampling ratio
  function automatic int unsigned b_phase(input int unsigned osr);
    return osr / 4;
  endfunction

  // Phase counter width
  function automatic int unsigned phase_width(input int unsigned osr);
    return (osr > 1) ? $clog2(osr) : 1;
  endfunction

  // Bit counter width (must hold the value DATA_W itself)
  function automatic int unsigned bitcnt_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage : manchester_pkg
`default_nettype wire

// File: rtl/manchester_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : manchester_decoder_if
//  Brief    : Line input, sample tick and decoded-word outputs of the receiver.
//  Revision : 1.0  initial release
// ============================================================================
interface manchester_decoder_if #(
  parameter int unsigned DATA_W = 8
);
  logic              sample_en;
  logic              line_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              err_o;
  logic              busy_o;

  // Driver side: supplies the tick and the serial line, observes results
  modport master (
    output sample_en, line_i,
    input  data_o, valid_o, err_o, busy_o
  );

  // Receiver side
  modport slave (
    input  sample_en, line_i,
    output data_o, valid_o, err_o, busy_o
  );
endinterface : manchester_decoder_if
`default_nettype wire

// File: rtl/manchester_decoder_line_sync.sv
`default_nettype none
// ============================================================================
//  Module   : line_sync
//  Brief    : Two-flop synchronizer for the asynchronous line plus a
//             tick-gated history register for rising-edge detection.
//  Revision : 1.0  initial release
// ============================================================================
module line_sync (
  input  logic clk,
  input  logic rst,
  input  logic sample_en_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer runs every clk so metastability settling never waits on a tick
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
    end
  end

  // Previous-tick level; edges are defined between consecutive sample ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else if (sample_en_i) begin
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule : line_sync
`default_nettype wire

// File: rtl/manchester_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : manchester_decoder
//  Brief    : Oversampled Manchester receiver (1 = low->high mid-bit).
//             Waits for OSR quiet ticks, locks to the start bit's mid-bit
//             rising edge, then samples each bit at 3/4 and 1/4 phase.
//  Revision : 1.0  initial release
// ============================================================================
module manchester_decoder
  import manchester_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OSR    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  manchester_decoder_if.slave  bus
);

  localparam int unsigned PH_W = phase_width(OSR);
  localparam int unsigned BC_W = bitcnt_width(DATA_W);
  localparam int unsigned QC_W = $clog2(OSR + 1);

  localparam logic [PH_W-1:0] PH_A    = PH_W'(a_phase(OSR));
  localparam logic [PH_W-1:0] PH_B    = PH_W'(b_phase(OSR));
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
  localparam logic [QC_W-1:0] QC_LAST = QC_W'(OSR - 1);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(DATA_W);

  logic level;
  logic rise;

  state_e            state_q,  state_d;
  logic [PH_W-1:0]   phase_q,  phase_d;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
  logic [QC_W-1:0]   qcnt_q,   qcnt_d;
  logic              a_q,      a_d;
  logic              aseen_q,  aseen_d;
  logic [DATA_W-1:0] shift_q,  shift_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic              valid_q,  valid_d;
  logic              err_q,    err_d;

  line_sync u_line_sync (
    .clk         (clk),
    .rst         (rst),
    .sample_en_i (bus.sample_en),
    .line_i      (bus.line_i),
    .level_o     (level),
    .rise_o      (rise)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= QUIET;
      phase_q  <= '0;
      bitcnt_q <= '0;
      qcnt_q   <= '0;
      a_q      <= 1'b0;
      aseen_q  <= 1'b0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      qcnt_q   <= qcnt_d;
      a_q      <= a_d;
      aseen_q  <= aseen_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: quiet detection, start lock, per-bit half sampling
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bitcnt_d = bitcnt_q;
    qcnt_d   = qcnt_q;
    a_d      = a_q;
    aseen_d  = aseen_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      QUIET: begin
        if (bus.sample_en) begin
          if (level) begin
            qcnt_d = '0;
          end else if (qcnt_q == QC_LAST) begin
            qcnt_d  = '0;
            state_d = IDLE;
          end else begin
            qcnt_d = qcnt_q + 1'b1;
          end
        end
      end

      IDLE: begin
        // The rising edge is the middle of the start '1': phase 0
        if (bus.sample_en && rise) begin
          state_d  = DATA;
          phase_d  = '0;
          bitcnt_d = '0;
          aseen_d  = 1'b0;
          shift_d  = '0;
        end
      end

      DATA: begin
        if (bitcnt_q == BC_FULL) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = QUIET;
          qcnt_d  = '0;
        end else if (bus.sample_en) begin
          phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
          if (phase_d == PH_A) begin
            a_d     = level;
            aseen_d = 1'b1;
          end else if (phase_d == PH_B && aseen_q) begin
            // The B point right after the start edge has no A yet; skip it
            aseen_d = 1'b0;
            if (a_q == level) begin
              err_d    = 1'b1;
              state_d  = QUIET;
              qcnt_d   = '0;
              bitcnt_d = '0;
              shift_d  = '0;
            end else begin
              shift_d  = {shift_q[DATA_W-2:0], level};
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = QUIET;
      end
    endcase
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.err_o   = err_q;
  assign bus.busy_o  = (state_q == DATA);

endmodule : manchester_decoder
`default_nettype wire

// File: tb/tb_manchester_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_manchester_decoder
//  Brief    : Scoreboard bench for manchester_decoder. Line waveforms are
//             built per sample tick; a waveform-level reference model predicts
//             the received words / code violations from the decoding rules.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_manchester_decoder;

  localparam int DATA_W = 8;
  localparam int OSR    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  manchester_decoder_if #(.DATA_W(DATA_W)) bus ();

  manchester_decoder #(.DATA_W(DATA_W), .OSR(OSR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit                is_err;
    logic [DATA_W-1:0] data;
    int                when;   // tick index of the output, -1 = not timed
  } ev_t;

  ev_t               exp_q[$];
  bit                wave[$];  // line level per sample tick
  int                n_tests = 0;
  int                n_fail  = 0;
  int                busy_cycles = 0;
  int                busy_run = 0;
  int                last_busy_len = 0;
  int                tick_cnt = 0;
  logic [DATA_W-1:0] last_good = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- waveform builders ----------------
  function automatic void add_level(input bit lvl, input int n);
    for (int i = 0; i < n; i++) wave.push_back(lvl);
  endfunction

  function automatic void add_bit(input bit b);
    add_level(!b, OSR/2);
    add_level(b, OSR/2);
  endfunction

  // Start '1' then data MSB first; bit 'viol' (if >=0) held flat at vlvl
  function automatic void add_frame(input logic [DATA_W-1:0] d, input int viol, input bit vlvl);
    add_bit(1'b1);
    for (int i = DATA_W-1; i >= 0; i--) begin
      if (i == viol) add_level(vlvl, OSR);
      else           add_bit(d[i]);
    end
  endfunction

  // ---------------- reference model ----------------
  // Works on the level seen at each tick. With fewer than 3 clks per tick the
  // synchronizer delay shows up as leading low ticks.
  task automatic model(input int period);
    bit s[$];
    int pos, low, e, ta, tb;
    logic [DATA_W-1:0] w;
    ev_t ev;
    for (int i = 0; i < 3 - period; i++) s.push_back(1'b0);
    foreach (wave[i]) s.push_back(wave[i]);
    pos = 0;
    low = 0;
    while (pos < s.size()) begin
      low = s[pos] ? 0 : low + 1;
      pos++;
      if (low == OSR) begin
        low = 0;
        while (pos < s.size() && !s[pos]) pos++;
        if (pos >= s.size()) break;
        e = pos;             // mid-bit of start '1'
        w = '0;
        for (int i = 0; i < DATA_W; i++) begin
          ta = e + (3*OSR)/4 + i*OSR;
          tb = e + OSR + OSR/4 + i*OSR;
          if (tb >= s.size()) begin
            pos = s.size();
            break;
          end
          if (s[ta] == s[tb]) begin
            ev.is_err = 1'b1; ev.data = '0;
            ev.when = (period == 1) ? tb : -1;
            exp_q.push_back(ev);
            pos = tb + 1;
            break;
          end
          w = {w[DATA_W-2:0], s[tb]};
          if (i == DATA_W-1) begin
            ev.is_err = 1'b0; ev.data = w;
            ev.when = (period == 1) ? tb + 1 : -1;
            exp_q.push_back(ev);
            // word delivery takes one clk; at one tick per clk that tick is lost
            pos = tb + ((period == 1) ? 2 : 1);
          end
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b1;
    bus.sample_en = 1'b0;
    bus.line_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data_o",  bus.data_o,  '0);
    check("reset_valid_o", bus.valid_o, 1'b0);
    check("reset_err_o",   bus.err_o,   1'b0);
    check("reset_busy_o",  bus.busy_o,  1'b0);
    rst = 1'b0;
  endtask

  task automatic run_wave(input int period);
    model(period);
    for (int j = 0; j < wave.size(); j++) begin
      bus.line_i = wave[j];
      for (int k = 1; k < period; k++) begin
        bus.sample_en = 1'b0;
        @(negedge clk);
      end
      bus.sample_en = 1'b1;
      @(negedge clk);
      bus.sample_en = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("pending_events", exp_q.size(), 0);
    exp_q.delete();
    wave.delete();
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    if (rst) tick_cnt <= 0;
    else if (bus.sample_en) tick_cnt <= tick_cnt + 1;
  end

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      last_good = '0;
      busy_run = 0;
    end else begin
      if (bus.busy_o) begin
        busy_cycles++;
        busy_run++;
      end else if (busy_run > 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
      end
      if (bus.valid_o || bus.err_o) begin
        check("valid_err_exclusive", bus.valid_o & bus.err_o, 1'b0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: valid=%0b err=%0b data=0x%0h, expected no output",
                   bus.valid_o, bus.err_o, bus.data_o);
        end else begin
          e = exp_q.pop_front();
          check("event_is_err", bus.err_o, e.is_err);
          if (e.when >= 0) check("event_tick", tick_cnt - 1, e.when);
          if (e.is_err) begin
            check("data_hold_on_err", bus.data_o, last_good);
          end else begin
            check("rx_word", bus.data_o, e.data);
            last_good = e.data;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int bc0;
    int per, gap, viol;
    bus.sample_en = 1'b0;
    bus.line_i = 1'b0;

    // Clean 0xA5 then 0x3C with bit 3 flat high
    do_reset();
    add_level(1'b0, 8);
    add_frame(8'hA5, -1, 1'b0);
    add_level(1'b0, 8);
    add_frame(8'h3C, 3, 1'b1);
    add_level(1'b0, 16);
    run_wave(1);
    check("hold_A5_after_err", bus.data_o, 8'hA5);

    // One tick every 3 clks, 0xFF; busy spans about DATA_W*OSR ticks
    do_reset();
    add_level(1'b0, 8);
    add_frame(8'hFF, -1, 1'b0);
    add_level(1'b0, 12);
    run_wave(3);
    check("word_FF", bus.data_o, 8'hFF);
    check("busy_len_range",
          (last_busy_len >= (DATA_W-1)*OSR*3) && (last_busy_len <= (DATA_W+1)*OSR*3), 1'b1);

    // Reset in the middle of data bit 4 of 0x81, then 0x42
    do_reset();
    add_level(1'b0, 8);
    add_frame(8'h81, -1, 1'b0);
    while (wave.size() > 8 + 4*OSR + OSR/2) void'(wave.pop_back());
    run_wave(1);
    do_reset();
    add_level(1'b0, 8);
    add_frame(8'h42, -1, 1'b0);
    add_level(1'b0, 12);
    run_wave(1);
    check("word_42_after_reset", bus.data_o, 8'h42);

    // Short gap: the start bit's leading half is also low time, so a 2-tick
    // gap leaves 6 quiet ticks and the second start edge is not accepted
    do_reset();
    add_level(1'b0, 8);
    add_frame(8'h11, -1, 1'b0);
    add_level(1'b0, 2);
    add_frame(8'h22, -1, 1'b0);
    add_level(1'b0, 12);
    run_wave(1);
    do_reset();
    add_level(1'b0, 8);
    add_frame(8'h11, -1, 1'b0);
    add_level(1'b0, 8);
    add_frame(8'h22, -1, 1'b0);
    add_level(1'b0, 12);
    run_wave(1);
    check("word_22_second", bus.data_o, 8'h22);

    // Line stuck high: never leaves QUIET
    do_reset();
    bc0 = busy_cycles;
    add_level(1'b1, 40);
    run_wave(1);
    check("stuck_high_busy", busy_cycles - bc0, 0);

    // Randomized frames, gaps, violations and tick rates
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      per = $urandom_range(1, 4);
      add_level(1'b0, 8);
      for (int f = 0; f < 3; f++) begin
        viol = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DATA_W-1) : -1;
        add_frame(DATA_W'($urandom), viol, 1'($urandom));
        gap = $urandom_range(0, 12);
        add_level(1'b0, gap);
      end
      add_level(1'b0, 12);
      run_wave(per);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL timeout: simulation did not reach the end, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_manchester_decoder
`default_nettype wire
